// File: rtl/usb_tx_nrzi_encoder.sv
// USB transmit line encoder: frames words with SYNC and EOP, bit-stuffs and NRZI-encodes them
// onto d_plus/d_minus at CLKS_PER_BIT clocks per line bit.
module usb_tx_nrzi_encoder #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned STUFF_LEN    = 6,
   parameter int unsigned EOP_SE0_BITS = 2,
   parameter bit          LOW_SPEED    = 1'b0
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_last,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              d_plus,
   output logic              d_minus,
   output logic              busy,
   output logic              eop,
   output logic              underrun
);

   localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W  = ($clog2(DATA_W) > 3) ? $clog2(DATA_W) : 3;
   localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);
   localparam int unsigned SE0_W  = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0]  SYNC_PEN  = IDX_W'(6);
   localparam logic [IDX_W-1:0]  SYNC_LAST = IDX_W'(7);
   localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(STUFF_LEN);
   localparam logic [SE0_W-1:0]  SE0_LAST  = SE0_W'(EOP_SE0_BITS - 1);
   localparam logic              J_DP      = ~LOW_SPEED;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SYNC    = 3'd1;
   localparam logic [2:0] DATA    = 3'd2;
   localparam logic [2:0] STUFF   = 3'd3;
   localparam logic [2:0] EOP_SE0 = 3'd4;
   localparam logic [2:0] EOP_J   = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ONES_W-1:0] ones_q, ones_d;
   logic [SE0_W-1:0]  se0_q, se0_d;
   logic              level_q, level_d;   // 1 = J
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic              hold_last_q, hold_last_d;
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              shift_last_q, shift_last_d;
   logic              dp_q, dp_d;
   logic              dm_q, dm_d;
   logic              busy_q, busy_d;
   logic              eop_q, eop_d;
   logic              underrun_q, underrun_d;

   logic              bit_tick;
   logic              accept;
   logic              take;
   logic              send;
   logic              send_bit;
   logic              stuff;
   logic              advance;
   logic              go_se0;
   logic              go_j;
   logic [DATA_W-1:0] shift_nxt;

   assign bit_tick = (state_q != IDLE) && (cnt_q == CNT_MAX);
   assign accept   = tx_valid && !hold_full_q;
   assign tx_ready = !hold_full_q;

   assign d_plus   = dp_q;
   assign d_minus  = dm_q;
   assign busy     = busy_q;
   assign eop      = eop_q;
   assign underrun = underrun_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      ones_d       = ones_q;
      se0_d        = se0_q;
      level_d      = level_q;
      hold_data_d  = hold_data_q;
      hold_last_d  = hold_last_q;
      hold_full_d  = hold_full_q;
      shift_d      = shift_q;
      shift_last_d = shift_last_q;
      dp_d         = dp_q;
      dm_d         = dm_q;
      busy_d       = busy_q;
      eop_d        = eop_q;
      underrun_d   = 1'b0;
      take         = 1'b0;
      send         = 1'b0;
      send_bit     = 1'b0;
      stuff        = 1'b0;
      advance      = 1'b0;
      go_se0       = 1'b0;
      go_j         = 1'b0;
      shift_nxt    = shift_q >> 1;

      if (state_q != IDLE) begin
         cnt_d = bit_tick ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            // First SYNC bit goes out on the edge after the word lands in the holding register.
            if (hold_full_q) begin
               state_d  = SYNC;
               take     = 1'b1;
               cnt_d    = '0;
               idx_d    = '0;
               ones_d   = '0;
               busy_d   = 1'b1;
               send     = 1'b1;
               send_bit = 1'b0;
            end
         end
         SYNC: begin
            if (bit_tick) begin
               send = 1'b1;
               if (idx_q == SYNC_LAST) begin
                  state_d  = DATA;
                  idx_d    = '0;
                  send_bit = shift_q[0];
               end else begin
                  idx_d    = idx_q + IDX_W'(1);
                  send_bit = (idx_q == SYNC_PEN);
               end
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (ones_q == ONES_MAX) begin
                  state_d = STUFF;
                  stuff   = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         STUFF: begin
            if (bit_tick) begin
               advance = 1'b1;
            end
         end
         EOP_SE0: begin
            if (bit_tick) begin
               if (se0_q == SE0_LAST) begin
                  state_d = EOP_J;
                  go_j    = 1'b1;
               end else begin
                  se0_d = se0_q + SE0_W'(1);
               end
            end
         end
         EOP_J: begin
            if (bit_tick) begin
               state_d = IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               eop_d   = 1'b0;
               level_d = 1'b1;
               ones_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Next data bit, or word boundary handling once the current word is exhausted.
      if (advance) begin
         if (idx_q != IDX_LAST) begin
            state_d  = DATA;
            idx_d    = idx_q + IDX_W'(1);
            shift_d  = shift_nxt;
            send     = 1'b1;
            send_bit = shift_nxt[0];
         end else if (shift_last_q) begin
            go_se0 = 1'b1;
         end else if (hold_full_q) begin
            state_d  = DATA;
            take     = 1'b1;
            idx_d    = '0;
            send     = 1'b1;
            send_bit = hold_data_q[0];
         end else begin
            go_se0     = 1'b1;
            underrun_d = 1'b1;
         end
      end

      if (stuff) begin
         level_d = ~level_q;
         ones_d  = '0;
      end

      if (send) begin
         if (send_bit) begin
            if (ones_q != ONES_MAX) begin
               ones_d = ones_q + ONES_W'(1);
            end
         end else begin
            level_d = ~level_q;
            ones_d  = '0;
         end
      end

      if (go_j) begin
         level_d = 1'b1;
      end

      if (send || stuff || go_j) begin
         dp_d = level_d ? J_DP : ~J_DP;
         dm_d = ~dp_d;
      end

      if (go_se0) begin
         state_d = EOP_SE0;
         se0_d   = '0;
         ones_d  = '0;
         dp_d    = 1'b0;
         dm_d    = 1'b0;
         eop_d   = 1'b1;
      end

      if (take) begin
         shift_d      = hold_data_q;
         shift_last_d = hold_last_q;
         hold_full_d  = 1'b0;
      end

      if (accept) begin
         hold_data_d = tx_data;
         hold_last_d = tx_last;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         ones_q       <= '0;
         se0_q        <= '0;
         level_q      <= 1'b1;
         hold_data_q  <= '0;
         hold_last_q  <= 1'b0;
         hold_full_q  <= 1'b0;
         shift_q      <= '0;
         shift_last_q <= 1'b0;
         dp_q         <= J_DP;
         dm_q         <= ~J_DP;
         busy_q       <= 1'b0;
         eop_q        <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         ones_q       <= ones_d;
         se0_q        <= se0_d;
         level_q      <= level_d;
         hold_data_q  <= hold_data_d;
         hold_last_q  <= hold_last_d;
         hold_full_q  <= hold_full_d;
         shift_q      <= shift_d;
         shift_last_q <= shift_last_d;
         dp_q         <= dp_d;
         dm_q         <= dm_d;
         busy_q       <= busy_d;
         eop_q        <= eop_d;
         underrun_q   <= underrun_d;
      end
   end

endmodule

// File: tb/tb_usb_tx_nrzi_encoder.sv
// Directed bench for usb_tx_nrzi_encoder: instance a at CLKS_PER_BIT=1, instance b at 4.
// Line symbols are written as J, K and 0 (SE0).
module tb_usb_tx_nrzi_encoder;

   localparam string SYNC_S = "KJKJKJKK";

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst = 1'b1;
   logic [7:0] a_data = 8'h00;
   logic       a_last = 1'b0;
   logic       a_valid = 1'b0;
   logic       a_ready, a_dp, a_dm, a_busy, a_eop, a_und;

   logic       b_rst = 1'b1;
   logic [7:0] b_data = 8'h00;
   logic       b_last = 1'b0;
   logic       b_valid = 1'b0;
   logic       b_ready, b_dp, b_dm, b_busy, b_eop, b_und;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] wq[2];
   bit         lq[2];

   string obs_line;
   int    obs_busy, obs_eop, obs_und, und_at, se0_at, obs_rises, obs_gap;
   string b_line;
   int    b_busy_cnt;

   usb_tx_nrzi_encoder #(.CLKS_PER_BIT(1)) dut_a (
      .clk      (clk),
      .n_rst    (a_rst),
      .tx_data  (a_data),
      .tx_last  (a_last),
      .tx_valid (a_valid),
      .tx_ready (a_ready),
      .d_plus   (a_dp),
      .d_minus  (a_dm),
      .busy     (a_busy),
      .eop      (a_eop),
      .underrun (a_und)
   );

   usb_tx_nrzi_encoder #(.CLKS_PER_BIT(4)) dut_b (
      .clk      (clk),
      .n_rst    (b_rst),
      .tx_data  (b_data),
      .tx_last  (b_last),
      .tx_valid (b_valid),
      .tx_ready (b_ready),
      .d_plus   (b_dp),
      .d_minus  (b_dm),
      .busy     (b_busy),
      .eop      (b_eop),
      .underrun (b_und)
   );

   function automatic string sym(input logic dp, input logic dm);
      case ({dp, dm})
         2'b10:   return "J";
         2'b01:   return "K";
         2'b00:   return "0";
         default: return "X";
      endcase
   endfunction

   function automatic string stretch(input string s, input int n);
      string r;
      r = "";
      for (int i = 0; i < s.len(); i++) begin
         for (int k = 0; k < n; k++) r = {r, s.substr(i, i)};
      end
      return r;
   endfunction

   // Offers wq/lq in order on instance a and records the line while busy.
   task automatic capture_a(input int nwords, input int ncyc);
      bit    acc;
      bit    prev_busy;
      int    widx;
      int    idle_run;
      string c;
      acc = 0; prev_busy = 0; widx = 0; idle_run = 0;
      obs_line = ""; obs_busy = 0; obs_eop = 0; obs_und = 0;
      und_at = -1; se0_at = -1; obs_rises = 0; obs_gap = -1;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         @(negedge clk);
         if (acc) widx++;
         if (widx < nwords) begin
            a_valid = 1'b1; a_data = wq[widx]; a_last = lq[widx];
         end else begin
            a_valid = 1'b0; a_data = 8'($urandom); a_last = 1'($urandom);
         end
         acc = a_valid && a_ready;
         if (a_busy) begin
            if (!prev_busy) begin
               obs_rises++;
               if (obs_rises > 1) obs_gap = idle_run;
            end
            c = sym(a_dp, a_dm);
            obs_line = {obs_line, c};
            obs_busy++;
            if (c == "0" && se0_at < 0) se0_at = obs_line.len() - 1;
            idle_run = 0;
         end else begin
            idle_run++;
         end
         if (a_eop) obs_eop++;
         if (a_und) begin
            obs_und++;
            if (und_at < 0) und_at = obs_line.len() - 1;
         end
         prev_busy = a_busy;
      end
      a_valid = 1'b0;
   endtask

   task automatic capture_b(input int nwords, input int ncyc, input int maxlen);
      bit acc;
      int widx;
      int cyc;
      acc = 0; widx = 0; cyc = 0;
      b_line = ""; b_busy_cnt = 0;
      while (cyc < ncyc && (maxlen == 0 || b_line.len() < maxlen)) begin
         @(negedge clk);
         cyc++;
         if (acc) widx++;
         if (widx < nwords) begin
            b_valid = 1'b1; b_data = wq[widx]; b_last = lq[widx];
         end else begin
            b_valid = 1'b0; b_data = 8'($urandom); b_last = 1'($urandom);
         end
         acc = b_valid && b_ready;
         if (b_busy) begin
            b_line = {b_line, sym(b_dp, b_dm)};
            b_busy_cnt++;
         end
      end
      b_valid = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      #1;
      a_rst = 1'b0;
      b_rst = 1'b0;
      #1;
      n_checks++;
      if ({a_dp, a_dm} !== 2'b10) $display("FAIL reset_line_a: got %b, expected 10", {a_dp, a_dm});
      else n_pass++;
      n_checks++;
      if ({b_dp, b_dm} !== 2'b10) $display("FAIL reset_line_b: got %b, expected 10", {b_dp, b_dm});
      else n_pass++;
      n_checks++;
      if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b, expected 1", a_ready);
      else n_pass++;
      n_checks++;
      if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", a_busy);
      else n_pass++;
      n_checks++;
      if (a_eop !== 1'b0) $display("FAIL reset_eop: got %b, expected 0", a_eop);
      else n_pass++;
      n_checks++;
      if (a_und !== 1'b0) $display("FAIL reset_underrun: got %b, expected 0", a_und);
      else n_pass++;
      repeat (2) @(negedge clk);
      a_rst = 1'b1;
      b_rst = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if ({a_dp, a_dm, a_ready, a_busy} !== 4'b1010) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles, expected 0", bad);
      else n_pass++;
   endtask

   task automatic test_single(input string name, input logic [7:0] w, input string exp_line,
                              input int exp_busy);
      wq[0] = w; lq[0] = 1'b1;
      capture_a(1, exp_busy + 8);
      n_checks++;
      if (obs_line != exp_line) $display("FAIL %s_line: got %s, expected %s", name, obs_line, exp_line);
      else n_pass++;
      n_checks++;
      if (obs_busy !== exp_busy) $display("FAIL %s_busy: got %0d, expected %0d", name, obs_busy, exp_busy);
      else n_pass++;
      n_checks++;
      if (obs_eop !== 3) $display("FAIL %s_eop: got %0d, expected 3", name, obs_eop);
      else n_pass++;
      n_checks++;
      if (obs_und !== 0) $display("FAIL %s_underrun: got %0d, expected 0", name, obs_und);
      else n_pass++;
      n_checks++;
      if ({a_dp, a_dm, a_busy} !== 3'b100) $display("FAIL %s_idle_after: got %b, expected 100", name, {a_dp, a_dm, a_busy});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      string exp;
      exp = {SYNC_S, "KJJKJJKK", "JKKKKKJK", "00J"};
      wq[0] = 8'hA5; lq[0] = 1'b0;
      wq[1] = 8'h3C; lq[1] = 1'b1;
      capture_a(2, 36);
      n_checks++;
      if (obs_line != exp) $display("FAIL b2b_line: got %s, expected %s", obs_line, exp);
      else n_pass++;
      n_checks++;
      if (obs_busy !== 27) $display("FAIL b2b_busy: got %0d, expected 27", obs_busy);
      else n_pass++;
      n_checks++;
      if (obs_und !== 0) $display("FAIL b2b_underrun: got %0d, expected 0", obs_und);
      else n_pass++;
      n_checks++;
      if (obs_rises !== 1) $display("FAIL b2b_packets: got %0d, expected 1", obs_rises);
      else n_pass++;
      n_checks++;
      if (obs_eop !== 3) $display("FAIL b2b_eop: got %0d, expected 3", obs_eop);
      else n_pass++;
   endtask

   task automatic test_underrun();
      string exp;
      exp = {SYNC_S, "JJKJJKJK", "00J"};
      wq[0] = 8'h12; lq[0] = 1'b0;
      capture_a(1, 28);
      n_checks++;
      if (obs_line != exp) $display("FAIL und_line: got %s, expected %s", obs_line, exp);
      else n_pass++;
      n_checks++;
      if (obs_und !== 1) $display("FAIL und_count: got %0d, expected 1", obs_und);
      else n_pass++;
      n_checks++;
      if (und_at !== 16) $display("FAIL und_position: got %0d, expected 16", und_at);
      else n_pass++;
      n_checks++;
      if (se0_at !== 16) $display("FAIL und_se0_start: got %0d, expected 16", se0_at);
      else n_pass++;
   endtask

   // Second tx_last word waits in the holding register through the first packet's EOP.
   task automatic test_hold_across_eop();
      string exp;
      exp = {SYNC_S, "JKJKJKJK", "00J", SYNC_S, "JKJKJKJK", "00J"};
      wq[0] = 8'h00; lq[0] = 1'b1;
      wq[1] = 8'h00; lq[1] = 1'b1;
      capture_a(2, 50);
      n_checks++;
      if (obs_line != exp) $display("FAIL hold_line: got %s, expected %s", obs_line, exp);
      else n_pass++;
      n_checks++;
      if (obs_rises !== 2) $display("FAIL hold_packets: got %0d, expected 2", obs_rises);
      else n_pass++;
      n_checks++;
      if (obs_gap !== 1) $display("FAIL hold_gap: got %0d, expected 1", obs_gap);
      else n_pass++;
      n_checks++;
      if (obs_eop !== 6) $display("FAIL hold_eop: got %0d, expected 6", obs_eop);
      else n_pass++;
      n_checks++;
      if (obs_und !== 0) $display("FAIL hold_underrun: got %0d, expected 0", obs_und);
      else n_pass++;
   endtask

   task automatic test_cpb4();
      string exp;
      wq[0] = 8'h00; lq[0] = 1'b0;
      wq[1] = 8'h00; lq[1] = 1'b1;
      capture_b(2, 60, 40);
      exp = stretch({SYNC_S, "JK"}, 4);
      n_checks++;
      if (b_line != exp) $display("FAIL cpb4_hold_line: got %s, expected %s", b_line, exp);
      else n_pass++;
      @(negedge clk);
      #1 b_rst = 1'b0;
      #1;
      n_checks++;
      if ({b_dp, b_dm} !== 2'b10) $display("FAIL cpb4_reset_line: got %b, expected 10", {b_dp, b_dm});
      else n_pass++;
      n_checks++;
      if (b_busy !== 1'b0) $display("FAIL cpb4_reset_busy: got %b, expected 0", b_busy);
      else n_pass++;
      n_checks++;
      if (b_ready !== 1'b1) $display("FAIL cpb4_reset_ready: got %b, expected 1", b_ready);
      else n_pass++;
      @(negedge clk);
      b_rst = 1'b1;
      wq[0] = 8'hFF; lq[0] = 1'b1;
      capture_b(1, 90, 0);
      exp = stretch({SYNC_S, "KKKKKJJJJ", "00J"}, 4);
      n_checks++;
      if (b_line != exp) $display("FAIL cpb4_restart_line: got %s, expected %s", b_line, exp);
      else n_pass++;
      n_checks++;
      if (b_busy_cnt !== 80) $display("FAIL cpb4_restart_busy: got %0d, expected 80", b_busy_cnt);
      else n_pass++;
      n_checks++;
      if ({b_dp, b_dm, b_busy} !== 3'b100) $display("FAIL cpb4_idle_after: got %b, expected 100", {b_dp, b_dm, b_busy});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single("zero", 8'h00, {SYNC_S, "JKJKJKJK", "00J"}, 19);
      test_single("ones", 8'hFF, {SYNC_S, "KKKKKJJJJ", "00J"}, 20);
      test_back_to_back();
      test_underrun();
      test_hold_across_eop();
      test_cpb4();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
